// File: rtl/rs_pkg.sv
// Shared reservation-station definitions: opcode constants used by decoder/EX
// and the "operand already valid" rename tag.
package rs_pkg;

  localparam int TAG_NONE = 0;

  localparam logic [5:0] OP_ADD = 6'h00;
  localparam logic [5:0] OP_SUB = 6'h01;
  localparam logic [5:0] OP_AND = 6'h02;
  localparam logic [5:0] OP_OR  = 6'h03;
  localparam logic [5:0] OP_XOR = 6'h04;
  localparam logic [5:0] OP_BEQ = 6'h10;
  localparam logic [5:0] OP_BNE = 6'h11;

endpackage

// File: rtl/rs_age_matrix.sv
// Age matrix for oldest-first select: age[j][i]=1 means entry j is older than entry i.
module rs_age_matrix #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DEPTH-1:0] alloc,
  input  logic [DEPTH-1:0] free,
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] grant
);

  logic [DEPTH-1:0] age [DEPTH];

  // A new entry is younger than all others; its own row and column are fully rewritten.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < DEPTH; j++) age[j] <= '0;
    end else if (en) begin
      if (clr) begin
        for (int j = 0; j < DEPTH; j++) age[j] <= '0;
      end else begin
        for (int j = 0; j < DEPTH; j++) begin
          for (int i = 0; i < DEPTH; i++) begin
            if (alloc[i])
              age[j][i] <= (j != i);
            else if (alloc[j])
              age[j][i] <= 1'b0;
            else if (free[i] || free[j])
              age[j][i] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic older;
      older = 1'b0;
      for (int j = 0; j < DEPTH; j++) older = older | (req[j] & age[j][i]);
      grant[i] = req[i] & ~older;
    end
  end

endmodule

// File: rtl/rs_age_pool.sv
// Reservation station with broadcast wakeup and oldest-ready-first issue.
// Optional build macro RS_WAKE_BYPASS_EN lets dispatch capture same-cycle broadcasts.
module rs_age_pool
  import rs_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32,
  parameter int OP_W   = 6,
  parameter int ADDR_W = 32,
  parameter int IMM_W  = 32,
  parameter int WAKE_N = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     clr,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [OP_W-1:0]          disp_op,
  input  logic [ADDR_W-1:0]        disp_pc,
  input  logic [IMM_W-1:0]         disp_imm,
  input  logic [TAG_W-1:0]         disp_rd_tag,
  input  logic [TAG_W-1:0]         disp_rs1_tag,
  input  logic [TAG_W-1:0]         disp_rs2_tag,
  input  logic [DATA_W-1:0]        disp_rs1_dt,
  input  logic [DATA_W-1:0]        disp_rs2_dt,
  input  logic [WAKE_N-1:0]        wake_en,
  input  logic [WAKE_N*TAG_W-1:0]  wake_tag,
  input  logic [WAKE_N*DATA_W-1:0] wake_dt,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OP_W-1:0]          iss_op,
  output logic [ADDR_W-1:0]        iss_pc,
  output logic [IMM_W-1:0]         iss_imm,
  output logic [TAG_W-1:0]         iss_rd_tag,
  output logic [DATA_W-1:0]        iss_rs1_dt,
  output logic [DATA_W-1:0]        iss_rs2_dt,
  output logic [CNT_W-1:0]         count
);

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] pc;
    logic [IMM_W-1:0]  imm;
    logic [TAG_W-1:0]  rd_tag;
    logic [TAG_W-1:0]  rs1_tag;
    logic [TAG_W-1:0]  rs2_tag;
    logic [DATA_W-1:0] rs1_dt;
    logic [DATA_W-1:0] rs2_dt;
    logic              rs1_ready;
    logic              rs2_ready;
  } entry_t;

  // Returns {hit, data}; scanning high to low lets the lowest matching port win.
  function automatic logic [DATA_W:0] wake_lookup(
    input logic [TAG_W-1:0]         tag,
    input logic [WAKE_N-1:0]        en,
    input logic [WAKE_N*TAG_W-1:0]  tags,
    input logic [WAKE_N*DATA_W-1:0] dts
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int k = WAKE_N - 1; k >= 0; k--) begin
      if (en[k] && tag != TAG_W'(TAG_NONE) && tags[k*TAG_W +: TAG_W] == tag)
        r = {1'b1, dts[k*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  entry_t           ent [DEPTH];
  entry_t           new_ent;
  logic [DATA_W:0]  w1 [DEPTH];
  logic [DATA_W:0]  w2 [DEPTH];
  logic [DEPTH-1:0] valid_vec, req, grant, alloc, free;
  logic             alloc_found, fire, iss_load, iss_take;

  always_comb begin
    valid_vec = '0;
    req       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = ent[i].valid;
      req[i]       = ent[i].valid & ent[i].rs1_ready & ent[i].rs2_ready;
      w1[i]        = wake_lookup(ent[i].rs1_tag, wake_en, wake_tag, wake_dt);
      w2[i]        = wake_lookup(ent[i].rs2_tag, wake_en, wake_tag, wake_dt);
    end
  end

  assign disp_ready = rdy & ~&valid_vec;
  assign fire       = disp_valid & disp_ready;
  assign iss_load   = rdy & (~iss_valid | iss_ready);
  assign iss_take   = iss_load & |grant;
  assign free       = iss_load ? grant : '0;

  always_comb begin
    alloc       = '0;
    alloc_found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid_vec[i] && !alloc_found) begin
        alloc[i]    = fire;
        alloc_found = 1'b1;
      end
    end
  end

`ifdef RS_WAKE_BYPASS_EN
  logic [DATA_W:0] bw1, bw2;
  assign bw1 = wake_lookup(disp_rs1_tag, wake_en, wake_tag, wake_dt);
  assign bw2 = wake_lookup(disp_rs2_tag, wake_en, wake_tag, wake_dt);
`endif

  always_comb begin
    new_ent           = '0;
    new_ent.valid     = 1'b1;
    new_ent.op        = disp_op;
    new_ent.pc        = disp_pc;
    new_ent.imm       = disp_imm;
    new_ent.rd_tag    = disp_rd_tag;
    new_ent.rs1_tag   = disp_rs1_tag;
    new_ent.rs2_tag   = disp_rs2_tag;
    new_ent.rs1_dt    = disp_rs1_dt;
    new_ent.rs2_dt    = disp_rs2_dt;
    new_ent.rs1_ready = (disp_rs1_tag == TAG_W'(TAG_NONE));
    new_ent.rs2_ready = (disp_rs2_tag == TAG_W'(TAG_NONE));
`ifdef RS_WAKE_BYPASS_EN
    if (!new_ent.rs1_ready && bw1[DATA_W]) begin
      new_ent.rs1_ready = 1'b1;
      new_ent.rs1_dt    = bw1[DATA_W-1:0];
    end
    if (!new_ent.rs2_ready && bw2[DATA_W]) begin
      new_ent.rs2_ready = 1'b1;
      new_ent.rs2_dt    = bw2[DATA_W-1:0];
    end
`endif
  end

  rs_age_matrix #(.DEPTH(DEPTH)) u_age (
    .clk   (clk),
    .rst   (rst),
    .en    (rdy),
    .clr   (clr),
    .alloc (alloc),
    .free  (free),
    .req   (req),
    .grant (grant)
  );

  // Flush wins over dispatch, wakeup and issue; rdy=0 freezes everything.
  always_ff @(posedge clk) begin
    if (!rst || (rdy && clr)) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      iss_valid  <= 1'b0;
      iss_op     <= '0;
      iss_pc     <= '0;
      iss_imm    <= '0;
      iss_rd_tag <= '0;
      iss_rs1_dt <= '0;
      iss_rs2_dt <= '0;
      count      <= '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (free[i]) begin
          ent[i].valid <= 1'b0;
        end else if (alloc[i]) begin
          ent[i] <= new_ent;
        end else if (ent[i].valid) begin
          if (!ent[i].rs1_ready && w1[i][DATA_W]) begin
            ent[i].rs1_ready <= 1'b1;
            ent[i].rs1_dt    <= w1[i][DATA_W-1:0];
          end
          if (!ent[i].rs2_ready && w2[i][DATA_W]) begin
            ent[i].rs2_ready <= 1'b1;
            ent[i].rs2_dt    <= w2[i][DATA_W-1:0];
          end
        end
      end
      if (iss_load) begin
        iss_valid <= |grant;
        for (int i = 0; i < DEPTH; i++) begin
          if (grant[i]) begin
            iss_op     <= ent[i].op;
            iss_pc     <= ent[i].pc;
            iss_imm    <= ent[i].imm;
            iss_rd_tag <= ent[i].rd_tag;
            iss_rs1_dt <= ent[i].rs1_dt;
            iss_rs2_dt <= ent[i].rs2_dt;
          end
        end
      end
      count <= count + CNT_W'(fire) - CNT_W'(iss_take);
    end
  end

endmodule

// File: tb/tb_rs_age_pool.sv
// Directed bench for rs_age_pool: reset, latency, age order, full/backpressure,
// dual wake, bypass (RS_WAKE_BYPASS_EN) and flush.
module tb_rs_age_pool;
  import rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, clr;
  logic        disp_valid, disp_ready;
  logic [5:0]  disp_op;
  logic [31:0] disp_pc, disp_imm;
  logic [3:0]  disp_rd_tag, disp_rs1_tag, disp_rs2_tag;
  logic [31:0] disp_rs1_dt, disp_rs2_dt;
  logic [1:0]  wake_en;
  logic [7:0]  wake_tag;
  logic [63:0] wake_dt;
  logic        iss_valid, iss_ready;
  logic [5:0]  iss_op;
  logic [31:0] iss_pc, iss_imm;
  logic [3:0]  iss_rd_tag;
  logic [31:0] iss_rs1_dt, iss_rs2_dt;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rs_age_pool dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_op(disp_op), .disp_pc(disp_pc), .disp_imm(disp_imm),
    .disp_rd_tag(disp_rd_tag), .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
    .disp_rs1_dt(disp_rs1_dt), .disp_rs2_dt(disp_rs2_dt),
    .wake_en(wake_en), .wake_tag(wake_tag), .wake_dt(wake_dt),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op(iss_op), .iss_pc(iss_pc), .iss_imm(iss_imm), .iss_rd_tag(iss_rd_tag),
    .iss_rs1_dt(iss_rs1_dt), .iss_rs2_dt(iss_rs2_dt),
    .count(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [3:0] rd,
                               input logic [3:0] t1, input logic [3:0] t2,
                               input logic [31:0] d1, input logic [31:0] d2);
    disp_valid   = v;
    disp_op      = op;
    disp_rd_tag  = rd;
    disp_pc      = {26'd0, rd, 2'b00};
    disp_imm     = {28'd0, rd} + 32'h100;
    disp_rs1_tag = t1;
    disp_rs2_tag = t2;
    disp_rs1_dt  = d1;
    disp_rs2_dt  = d2;
  endtask

  task automatic applyWake(input logic [1:0] en, input logic [3:0] t0, input logic [31:0] d0,
                           input logic [3:0] t1, input logic [31:0] d1);
    wake_en  = en;
    wake_tag = {t1, t0};
    wake_dt  = {d1, d0};
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; clr = 1'b0; iss_ready = 1'b0;
    applyWake(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    // Reset with a dispatch request held high
    applyStimulus(1'b1, OP_ADD, 4'd1, 4'd0, 4'd0, 32'd1, 32'd2);
    tick(); tick();
    rst = 1'b1;
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0);
    checkOutput("reset_disp_ready", 64'(disp_ready), 64'd1);
    checkOutput("reset_iss_valid", 64'(iss_valid), 64'd0);
    checkOutput("reset_count", 64'(count), 64'd0);
    tick();
    checkOutput("reset_nothing_enq", 64'(count), 64'd0);
    checkOutput("reset_no_issue", 64'(iss_valid), 64'd0);

    // Ready op latency
    iss_ready = 1'b1;
    applyStimulus(1'b1, OP_ADD, 4'd1, 4'd0, 4'd0, 32'd5, 32'd7);
    tick();
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0);
    checkOutput("ready_count1", 64'(count), 64'd1);
    checkOutput("ready_not_yet", 64'(iss_valid), 64'd0);
    tick();
    checkOutput("ready_iss_valid", 64'(iss_valid), 64'd1);
    checkOutput("ready_rs1", 64'(iss_rs1_dt), 64'd5);
    checkOutput("ready_rs2", 64'(iss_rs2_dt), 64'd7);
    checkOutput("ready_rd", 64'(iss_rd_tag), 64'd1);
    checkOutput("ready_op", 64'(iss_op), 64'(OP_ADD));
    checkOutput("ready_pc", 64'(iss_pc), 64'h4);
    checkOutput("ready_imm", 64'(iss_imm), 64'h101);
    checkOutput("ready_count0", 64'(count), 64'd0);
    tick();
    checkOutput("ready_drained", 64'(iss_valid), 64'd0);

    // rdy=0 freezes
    rdy = 1'b0;
    applyStimulus(1'b1, OP_SUB, 4'd2, 4'd0, 4'd0, 32'd1, 32'd1);
    #1 checkOutput("frozen_disp_ready", 64'(disp_ready), 64'd0);
    tick();
    checkOutput("frozen_count", 64'(count), 64'd0);
    rdy = 1'b1;
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0);
    tick();
    checkOutput("frozen_no_issue", 64'(iss_valid), 64'd0);

    // Age order: A(pending), B(ready), C(pending)
    applyStimulus(1'b1, OP_SUB, 4'd2, 4'd3, 4'd0, 32'd0, 32'd1);
    tick();
    applyStimulus(1'b1, OP_AND, 4'd3, 4'd0, 4'd0, 32'h20, 32'h21);
    tick();
    applyStimulus(1'b1, OP_OR, 4'd4, 4'd3, 4'd0, 32'd0, 32'd2);
    tick();
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0);
    checkOutput("age_B_rd", 64'(iss_rd_tag), 64'd3);
    checkOutput("age_B_rs1", 64'(iss_rs1_dt), 64'h20);
    checkOutput("age_count2", 64'(count), 64'd2);
    applyWake(2'b01, 4'd3, 32'h10, 4'd0, 32'd0);
    tick();
    applyWake(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    checkOutput("age_gap", 64'(iss_valid), 64'd0);
    tick();
    checkOutput("age_A_rd", 64'(iss_rd_tag), 64'd2);
    checkOutput("age_A_rs1", 64'(iss_rs1_dt), 64'h10);
    checkOutput("age_A_rs2", 64'(iss_rs2_dt), 64'd1);
    tick();
    checkOutput("age_C_rd", 64'(iss_rd_tag), 64'd4);
    checkOutput("age_C_rs1", 64'(iss_rs1_dt), 64'h10);
    checkOutput("age_C_count", 64'(count), 64'd0);
    tick();
    checkOutput("age_drained", 64'(iss_valid), 64'd0);

    // Full and backpressure
    iss_ready = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(1'b1, OP_XOR, 4'(k), 4'd9, 4'd0, 32'd0, 32'(k));
      tick();
    end
    checkOutput("full_count", 64'(count), 64'd8);
    checkOutput("full_disp_ready", 64'(disp_ready), 64'd0);
    applyStimulus(1'b1, OP_XOR, 4'd15, 4'd0, 4'd0, 32'd0, 32'd0);
    tick();
    checkOutput("full_no_overflow", 64'(count), 64'd8);
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0);
    applyWake(2'b01, 4'd9, 32'h99, 4'd0, 32'd0);
    tick();
    applyWake(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    checkOutput("full_wake_no_issue", 64'(iss_valid), 64'd0);
    tick();
    checkOutput("full_first_rd", 64'(iss_rd_tag), 64'd1);
    checkOutput("full_first_count", 64'(count), 64'd7);
    tick(); tick();
    checkOutput("bp_hold_valid", 64'(iss_valid), 64'd1);
    checkOutput("bp_hold_rd", 64'(iss_rd_tag), 64'd1);
    checkOutput("bp_hold_rs1", 64'(iss_rs1_dt), 64'h99);
    checkOutput("bp_hold_count", 64'(count), 64'd7);
    iss_ready = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      tick();
      checkOutput("drain_rd", 64'(iss_rd_tag), 64'(k));
      checkOutput("drain_rs2", 64'(iss_rs2_dt), 64'(k));
      checkOutput("drain_count", 64'(count), 64'(8 - k));
    end
    tick();
    checkOutput("drain_done", 64'(iss_valid), 64'd0);

    // Dual wake, tag-0 broadcast, lowest port priority
    applyStimulus(1'b1, OP_BEQ, 4'd5, 4'd4, 4'd5, 32'd0, 32'd0);
    tick();
    applyStimulus(1'b1, OP_BNE, 4'd6, 4'd0, 4'd0, 32'h33, 32'h44);
    applyWake(2'b01, 4'd0, 32'hEE, 4'd0, 32'd0);
    tick();
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0);
    applyWake(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    tick();
    checkOutput("tag0_rd", 64'(iss_rd_tag), 64'd6);
    checkOutput("tag0_rs1", 64'(iss_rs1_dt), 64'h33);
    checkOutput("tag0_rs2", 64'(iss_rs2_dt), 64'h44);
    checkOutput("tag0_count", 64'(count), 64'd1);
    applyWake(2'b11, 4'd4, 32'hA, 4'd5, 32'hB);
    tick();
    applyWake(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    tick();
    checkOutput("dual_rd", 64'(iss_rd_tag), 64'd5);
    checkOutput("dual_rs1", 64'(iss_rs1_dt), 64'hA);
    checkOutput("dual_rs2", 64'(iss_rs2_dt), 64'hB);
    applyStimulus(1'b1, OP_ADD, 4'd7, 4'd7, 4'd0, 32'd0, 32'd3);
    tick();
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0);
    applyWake(2'b11, 4'd7, 32'h1, 4'd7, 32'h2);
    tick();
    applyWake(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    tick();
    checkOutput("prio_rd", 64'(iss_rd_tag), 64'd7);
    checkOutput("prio_rs1", 64'(iss_rs1_dt), 64'h1);
    tick();
    checkOutput("prio_drained", 64'(iss_valid), 64'd0);

    // Dispatch while the producer tag broadcasts
    applyStimulus(1'b1, OP_ADD, 4'd8, 4'd6, 4'd0, 32'd0, 32'd9);
    applyWake(2'b01, 4'd6, 32'h66, 4'd0, 32'd0);
    tick();
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0);
    applyWake(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    tick();
`ifdef RS_WAKE_BYPASS_EN
    checkOutput("bypass_valid", 64'(iss_valid), 64'd1);
    checkOutput("bypass_rs1", 64'(iss_rs1_dt), 64'h66);
    checkOutput("bypass_count", 64'(count), 64'd0);
    tick();
`else
    checkOutput("nobypass_pending", 64'(iss_valid), 64'd0);
    checkOutput("nobypass_count", 64'(count), 64'd1);
    applyWake(2'b01, 4'd6, 32'h77, 4'd0, 32'd0);
    tick();
    applyWake(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    tick();
    checkOutput("nobypass_rs1", 64'(iss_rs1_dt), 64'h77);
    checkOutput("nobypass_rd", 64'(iss_rd_tag), 64'd8);
    tick();
`endif

    // Flush with 5 entries, a held issue register and a simultaneous dispatch
    iss_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, OP_OR, 4'(k), 4'd0, 4'd0, 32'(k), 32'd0);
      tick();
    end
    checkOutput("preflush_count", 64'(count), 64'd5);
    checkOutput("preflush_valid", 64'(iss_valid), 64'd1);
    applyStimulus(1'b1, OP_OR, 4'd9, 4'd0, 4'd0, 32'd9, 32'd0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    applyStimulus(1'b0, OP_ADD, 4'd0, 4'd0, 4'd0, 32'd0, 32'd0);
    checkOutput("flush_count", 64'(count), 64'd0);
    checkOutput("flush_iss_valid", 64'(iss_valid), 64'd0);
    checkOutput("flush_iss_rd", 64'(iss_rd_tag), 64'd0);
    checkOutput("flush_iss_rs1", 64'(iss_rs1_dt), 64'd0);
    iss_ready = 1'b1;
    tick();
    checkOutput("flush_dropped_valid", 64'(iss_valid), 64'd0);
    checkOutput("flush_dropped_count", 64'(count), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
